// File: rtl/vol_status_pio_if.sv
// -----------------------------------------------------------------------------
// vol_status_pio_if
//
// Avalon-MM slave bus bundle for the volume-status PIO.
//
// Signals:
//   address    [1:0]  word address (register select)
//   chipselect        slave select
//   write_n           active-low write strobe
//   writedata  [31:0] write data
//   readdata   [31:0] registered read data (one cycle latency)
//   irq               interrupt request, active-high
//
// Modports:
//   master - system-bus side (drives address/strobes/data, receives readdata/irq)
//   slave  - PIO side
// -----------------------------------------------------------------------------
interface vol_status_pio_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata,
        input  irq
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata,
        output irq
    );
endinterface : vol_status_pio_if

// File: rtl/vol_status_pio.sv
// -----------------------------------------------------------------------------
// vol_status_pio
//
// WIDTH-bit status input port on an Avalon-MM slave. Each input bit is
// synchronised, delayed once more for edge detection, and detected edges are
// latched in EDGE_CAPTURE until firmware clears them (write-1-to-clear), so a
// short status pulse from the acquisition side is never missed.
//
// Register map (word addresses):
//   0 DATA          RO    synchronised input level
//   1 (reserved)    reads 0, writes ignored
//   2 IRQ_MASK      RW    interrupt mask (only with VOL_STATUS_PIO_IRQ_EN)
//   3 EDGE_CAPTURE  R/W1C latched edges
//   Unused upper readdata bits read 0.
//
// Parameters:
//   WIDTH       number of input bits (1..32)
//   SYNC_STAGES synchroniser depth per bit (>= 2)
//   EDGE_TYPE   0 rising, 1 falling, 2 any edge
//
// Ports:
//   clk      system clock
//   reset    asynchronous reset, active-high; clears every flop
//   in_port  asynchronous status inputs
//   bus      Avalon-MM slave (vol_status_pio_if.slave)
//
// Build option:
//   VOL_STATUS_PIO_IRQ_EN - when defined, the IRQ_MASK register exists and
//   irq = |(edge_capture & irq_mask). When undefined there are no mask flops,
//   address 2 reads 0 and ignores writes, and irq is tied to 0; edge capture
//   still works for polling.
// -----------------------------------------------------------------------------
module vol_status_pio #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  in_port,
    vol_status_pio_if.slave   bus
);

    // -------------------------------------------------------------------------
    // Bus decode
    // -------------------------------------------------------------------------
    logic             wr_en;
    logic             wr_edge;
    logic [WIDTH-1:0] clr_mask;

    assign wr_en    = bus.chipselect & ~bus.write_n;
    assign wr_edge  = wr_en & (bus.address == 2'd3);
    assign clr_mask = wr_edge ? bus.writedata[WIDTH-1:0] : '0;

    // Upper writedata bits beyond WIDTH carry no meaning for this block.
    logic unused_wdata;
    assign unused_wdata = ^bus.writedata;

    // -------------------------------------------------------------------------
    // Synchroniser chain plus one delay stage for edge detection
    // -------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_chain_q, sync_chain_d;
    logic [WIDTH-1:0]                  sync_dly_q, sync_dly_d;
    logic [WIDTH-1:0]                  sync_lvl;

    assign sync_lvl = sync_chain_q[SYNC_STAGES-1];

    always_comb begin
        sync_chain_d = {sync_chain_q[SYNC_STAGES-2:0], in_port};
        sync_dly_d   = sync_lvl;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_chain_q <= '0;
            sync_dly_q   <= '0;
        end else begin
            sync_chain_q <= sync_chain_d;
            sync_dly_q   <= sync_dly_d;
        end
    end

    // -------------------------------------------------------------------------
    // Edge detect and capture
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] edge_cap_q, edge_cap_d;

    always_comb begin
        edge_det = '0;
        case (EDGE_TYPE)
            1:       edge_det = ~sync_lvl & sync_dly_q;
            2:       edge_det =  sync_lvl ^ sync_dly_q;
            default: edge_det =  sync_lvl & ~sync_dly_q;
        endcase
    end

    // The clear is applied first and the new edge ORed in afterwards, so a
    // fresh edge arriving in the same cycle as its clear is not lost.
    always_comb begin
        edge_cap_d = (edge_cap_q & ~clr_mask) | edge_det;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            edge_cap_q <= '0;
        end else begin
            edge_cap_q <= edge_cap_d;
        end
    end

    // -------------------------------------------------------------------------
    // Interrupt mask and irq
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] mask_rd;

`ifdef VOL_STATUS_PIO_IRQ_EN
    logic [WIDTH-1:0] irq_mask_q, irq_mask_d;

    always_comb begin
        irq_mask_d = irq_mask_q;
        if (wr_en && (bus.address == 2'd2)) begin
            irq_mask_d = bus.writedata[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_mask_q <= '0;
        end else begin
            irq_mask_q <= irq_mask_d;
        end
    end

    assign mask_rd = irq_mask_q;
    // Combinational from registers: asserts in the same cycle the capture
    // bit sets, and the cycle after an already-captured bit is unmasked.
    assign bus.irq = |(edge_cap_q & irq_mask_q);
`else
    assign mask_rd = '0;
    assign bus.irq = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Read path: registered every clock regardless of chipselect, so the
    // value presented is the register contents before the current edge.
    // -------------------------------------------------------------------------
    logic [31:0] readdata_q, readdata_d;

    always_comb begin
        readdata_d = '0;
        case (bus.address)
            2'd0:    readdata_d[WIDTH-1:0] = sync_lvl;
            2'd2:    readdata_d[WIDTH-1:0] = mask_rd;
            2'd3:    readdata_d[WIDTH-1:0] = edge_cap_q;
            default: readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata_q <= '0;
        end else begin
            readdata_q <= readdata_d;
        end
    end

    assign bus.readdata = readdata_q;

endmodule : vol_status_pio

// File: tb/tb_vol_status_pio.sv
// -----------------------------------------------------------------------------
// tb_vol_status_pio
//
// Three instances (EDGE_TYPE 0, 1, 2) share the same bus and in_port stimulus.
// The driver applies one cycle of stimulus before each rising edge and pushes
// the expected post-edge readdata/irq of every instance into a queue; a
// separate monitor pops one entry after each edge and compares.
//
// Reference model: the input value sampled at every edge is kept in a history
// array. The synchronised level seen before edge t is the sample from edge
// t-SYNC_STAGES and the delayed level the one before it; samples taken at or
// before the last edge with reset asserted count as 0.
// -----------------------------------------------------------------------------
module tb_vol_status_pio;
    localparam int W    = 8;
    localparam int SS   = 2;
    localparam int MAXC = 8192;

`ifdef VOL_STATUS_PIO_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    typedef struct packed {
        int unsigned     idx;
        logic [2:0][31:0] rd;
        logic [2:0]       irq;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] in_port;

    vol_status_pio_if bus0 ();
    vol_status_pio_if bus1 ();
    vol_status_pio_if bus2 ();

    vol_status_pio #(.WIDTH(W), .SYNC_STAGES(SS), .EDGE_TYPE(0)) dut0 (
        .clk(clk), .reset(reset), .in_port(in_port), .bus(bus0));
    vol_status_pio #(.WIDTH(W), .SYNC_STAGES(SS), .EDGE_TYPE(1)) dut1 (
        .clk(clk), .reset(reset), .in_port(in_port), .bus(bus1));
    vol_status_pio #(.WIDTH(W), .SYNC_STAGES(SS), .EDGE_TYPE(2)) dut2 (
        .clk(clk), .reset(reset), .in_port(in_port), .bus(bus2));

    always #5 clk = ~clk;

    // Scoreboard and counters
    exp_t exp_q[$];
    int   vectors    = 0;
    int   miscompares = 0;

    // Reference model state
    logic [W-1:0] hist [MAXC];
    logic [W-1:0] cap  [3];
    logic [W-1:0] mask;
    int           rst_edge;
    int           cyc;

    function automatic logic [W-1:0] hv(input int i);
        if (i < 0 || i <= rst_edge) return '0;
        return hist[i];
    endfunction

    function automatic logic [W-1:0] edge_of(input int et, input logic [W-1:0] now,
                                             input logic [W-1:0] old);
        case (et)
            0:       return now & ~old;
            1:       return ~now & old;
            default: return now ^ old;
        endcase
    endfunction

    task automatic model_step(input logic r, input logic cs, input logic wn,
                              input logic [1:0] a, input logic [31:0] wd,
                              input logic [W-1:0] inp);
        exp_t         e;
        logic [W-1:0] s_now, s_old, clr;
        e     = '0;
        e.idx = cyc;
        hist[cyc] = inp;
        if (r) begin
            rst_edge = cyc;
            mask     = '0;
            for (int i = 0; i < 3; i++) cap[i] = '0;
        end else begin
            s_now = hv(cyc - SS);
            s_old = hv(cyc - SS - 1);
            clr   = (cs && !wn && a == 2'd3) ? wd[W-1:0] : '0;
            for (int i = 0; i < 3; i++) begin
                case (a)
                    2'd0:    e.rd[i] = 32'(s_now);
                    2'd2:    e.rd[i] = 32'(mask);
                    2'd3:    e.rd[i] = 32'(cap[i]);
                    default: e.rd[i] = 32'd0;
                endcase
            end
            for (int i = 0; i < 3; i++)
                cap[i] = (cap[i] & ~clr) | edge_of(i, s_now, s_old);
            if (IRQ_EN && cs && !wn && a == 2'd2) mask = wd[W-1:0];
            for (int i = 0; i < 3; i++)
                e.irq[i] = IRQ_EN && ((cap[i] & mask) != '0);
        end
        exp_q.push_back(e);
    endtask

    // One stimulus cycle: drive at the falling edge, model the next rising edge.
    task automatic cycle(input logic r, input logic cs, input logic wn,
                         input logic [1:0] a, input logic [31:0] wd,
                         input logic [W-1:0] inp);
        @(negedge clk);
        reset           = r;
        in_port         = inp;
        bus0.chipselect = cs;  bus1.chipselect = cs;  bus2.chipselect = cs;
        bus0.write_n    = wn;  bus1.write_n    = wn;  bus2.write_n    = wn;
        bus0.address    = a;   bus1.address    = a;   bus2.address    = a;
        bus0.writedata  = wd;  bus1.writedata  = wd;  bus2.writedata  = wd;
        model_step(r, cs, wn, a, wd, inp);
        cyc++;
    endtask

    task automatic rd(input logic [1:0] a, input logic [W-1:0] inp);
        cycle(1'b0, 1'b1, 1'b1, a, 32'd0, inp);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [W-1:0] inp);
        cycle(1'b0, 1'b1, 1'b0, a, d, inp);
    endtask

    task automatic rst_cyc(input logic [1:0] a, input logic [W-1:0] inp);
        cycle(1'b1, 1'b0, 1'b1, a, 32'd0, inp);
    endtask

    // Monitor: compares every instance after every modelled edge.
    initial begin
        exp_t             e;
        logic [2:0][31:0] act_rd;
        logic [2:0]       act_irq;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e       = exp_q.pop_front();
                act_rd  = {bus2.readdata, bus1.readdata, bus0.readdata};
                act_irq = {bus2.irq, bus1.irq, bus0.irq};
                for (int i = 0; i < 3; i++) begin
                    vectors++;
                    if (act_rd[i] !== e.rd[i]) begin
                        miscompares++;
                        $display("FAIL readdata et%0d cyc %0d: got %h want %h",
                                 i, e.idx, act_rd[i], e.rd[i]);
                    end
                    vectors++;
                    if (act_irq[i] !== e.irq[i]) begin
                        miscompares++;
                        $display("FAIL irq et%0d cyc %0d: got %b want %b",
                                 i, e.idx, act_irq[i], e.irq[i]);
                    end
                end
            end
        end
    end

    initial begin
        logic         r, cs, wn;
        logic [1:0]   a;
        logic [31:0]  wd;
        logic [W-1:0] inp;

        rst_edge = -1;
        cyc      = 0;
        mask     = '0;
        for (int i = 0; i < 3; i++) cap[i] = '0;
        reset   = 1'b1;
        in_port = '0;
        bus0.chipselect = 1'b0; bus1.chipselect = 1'b0; bus2.chipselect = 1'b0;
        bus0.write_n    = 1'b1; bus1.write_n    = 1'b1; bus2.write_n    = 1'b1;
        bus0.address    = 2'd0; bus1.address    = 2'd0; bus2.address    = 2'd0;
        bus0.writedata  = '0;   bus1.writedata  = '0;   bus2.writedata  = '0;

        // Reset with inputs low, then read DATA and EDGE_CAPTURE.
        repeat (3) rst_cyc(2'd0, 8'h00);
        rd(2'd0, 8'h00); rd(2'd3, 8'h00); rd(2'd3, 8'h00); rd(2'd2, 8'h00);

        // 0x00 -> 0x05: capture appears three edges later; DATA follows.
        for (int k = 0; k < 5; k++) rd(2'd3, 8'h05);
        rd(2'd0, 8'h05); rd(2'd0, 8'h05);

        // Mask bit2, drop bit2, then a one-cycle pulse on bit2; clear it.
        wr(2'd2, 32'h0000_0004, 8'h05);
        wr(2'd3, 32'h0000_00FF, 8'h01);
        for (int k = 0; k < 4; k++) rd(2'd3, 8'h01);
        wr(2'd3, 32'h0000_00FF, 8'h01);
        rd(2'd3, 8'h05);
        for (int k = 0; k < 4; k++) rd(2'd3, 8'h01);
        wr(2'd3, 32'h0000_0004, 8'h01);
        rd(2'd3, 8'h01); rd(2'd3, 8'h01); rd(2'd2, 8'h01);

        // Clear of bit2 in the same cycle a new rising edge on bit2 is detected.
        rd(2'd3, 8'h05);
        rd(2'd3, 8'h05);
        wr(2'd3, 32'h0000_0004, 8'h05);
        for (int k = 0; k < 3; k++) rd(2'd3, 8'h05);

        // Bit0 toggles 0->1->0 with a clear in between.
        wr(2'd3, 32'h0000_00FF, 8'h04);
        for (int k = 0; k < 4; k++) rd(2'd3, 8'h04);
        wr(2'd3, 32'h0000_00FF, 8'h04);
        for (int k = 0; k < 4; k++) rd(2'd3, 8'h05);
        wr(2'd3, 32'h0000_00FF, 8'h05);
        for (int k = 0; k < 4; k++) rd(2'd3, 8'h04);

        // Reserved address and DATA writes change nothing.
        wr(2'd1, 32'hFFFF_FFFF, 8'h04); wr(2'd0, 32'hFFFF_FFFF, 8'h04);
        rd(2'd1, 8'h04); rd(2'd0, 8'h04);

        // Fill capture, full mask, hold 0x80, then reset mid-run.
        for (int k = 0; k < 4; k++) rd(2'd3, 8'h00);
        for (int k = 0; k < 4; k++) rd(2'd3, 8'hFF);
        wr(2'd2, 32'h0000_00FF, 8'hFF);
        for (int k = 0; k < 4; k++) rd(2'd3, 8'h80);
        rst_cyc(2'd3, 8'h80); rst_cyc(2'd3, 8'h80);
        for (int k = 0; k < 6; k++) rd(2'd3, 8'h80);
        wr(2'd2, 32'h0000_00FF, 8'h80);
        rd(2'd3, 8'h80); rd(2'd2, 8'h80);

        // Randomised traffic.
        inp = 8'h00;
        for (int k = 0; k < 3000; k++) begin
            r  = ($urandom_range(0, 249) == 0);
            cs = ($urandom_range(0, 3) != 0);
            wn = ($urandom_range(0, 2) != 0);
            a  = 2'($urandom_range(0, 3));
            wd = $urandom;
            if ($urandom_range(0, 3) == 0) inp = W'($urandom);
            cycle(r, cs, wn, a, wd, inp);
        end

        // Drain the scoreboard within a bounded number of cycles.
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_vol_status_pio
